// File: rtl/dp_exec_ctrl_pkg.sv
// Shared definitions for the data-processing execute controller.
// Holds the ARM condition-code constants, the ALU opcode encoding and
// small opcode-class helpers used by the controller and the branch unit.
// Optional feature macro: DP_EXEC_CTRL_MOV_BYPASS_EN (MOV/MVN skip READ).
`ifndef WordWidth
`define WordWidth 32
`endif

package dp_exec_ctrl_pkg;

  // ARM condition field encodings
  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  // ALU opcode encodings (ARM data-processing order)
  typedef enum logic [3:0] {
    ALU_AND = 4'h0, ALU_EOR = 4'h1, ALU_SUB = 4'h2, ALU_RSB = 4'h3,
    ALU_ADD = 4'h4, ALU_ADC = 4'h5, ALU_SBC = 4'h6, ALU_RSC = 4'h7,
    ALU_TST = 4'h8, ALU_TEQ = 4'h9, ALU_CMP = 4'hA, ALU_CMN = 4'hB,
    ALU_ORR = 4'hC, ALU_MOV = 4'hD, ALU_BIC = 4'hE, ALU_MVN = 4'hF
  } alu_op_e;

  // Compare/test ops: never write Rd, always commit flags.
  function automatic logic is_test_op(input logic [3:0] op);
    return (op == ALU_TST) || (op == ALU_TEQ) || (op == ALU_CMP) || (op == ALU_CMN);
  endfunction

  // Arithmetic ops take all four flags from the ALU (including V).
  function automatic logic is_arith_op(input logic [3:0] op);
    return (op == ALU_SUB) || (op == ALU_RSB) || (op == ALU_ADD) || (op == ALU_ADC) ||
           (op == ALU_SBC) || (op == ALU_RSC) || (op == ALU_CMP) || (op == ALU_CMN);
  endfunction

  // Ops whose carry-in is the architectural C flag rather than the shifter carry.
  function automatic logic uses_flag_carry(input logic [3:0] op);
    return (op == ALU_ADC) || (op == ALU_SBC) || (op == ALU_RSC);
  endfunction

  // Ops that ignore Rn entirely.
  function automatic logic is_move_op(input logic [3:0] op);
    return (op == ALU_MOV) || (op == ALU_MVN);
  endfunction

endpackage

// File: rtl/dp_exec_ctrl_cond_check.sv
// Combinational ARM condition-code evaluator: decides whether an
// instruction with condition in_Cond executes given flags {C,N,Z,V}.
module cond_check
  import dp_exec_ctrl_pkg::*;
(
  input  logic [3:0] in_Cond,
  input  logic [3:0] in_CNZV,
  output logic       out_Pass
);

  logic flag_c, flag_n, flag_z, flag_v;

  assign flag_c = in_CNZV[3];
  assign flag_n = in_CNZV[2];
  assign flag_z = in_CNZV[1];
  assign flag_v = in_CNZV[0];

  // Decode the condition field against the current flags
  always_comb begin
    out_Pass = 1'b0;
    case (in_Cond)
      COND_EQ: out_Pass = flag_z;
      COND_NE: out_Pass = !flag_z;
      COND_CS: out_Pass = flag_c;
      COND_CC: out_Pass = !flag_c;
      COND_MI: out_Pass = flag_n;
      COND_PL: out_Pass = !flag_n;
      COND_VS: out_Pass = flag_v;
      COND_VC: out_Pass = !flag_v;
      COND_HI: out_Pass = flag_c && !flag_z;
      COND_LS: out_Pass = !flag_c || flag_z;
      COND_GE: out_Pass = (flag_n == flag_v);
      COND_LT: out_Pass = (flag_n != flag_v);
      COND_GT: out_Pass = !flag_z && (flag_n == flag_v);
      COND_LE: out_Pass = flag_z || (flag_n != flag_v);
      COND_AL: out_Pass = 1'b1;
      default: out_Pass = 1'b0;  // NV: never executes
    endcase
  end

endmodule

// File: rtl/dp_exec_ctrl.sv
// Multi-cycle sequencer for data-processing instructions. Accepts one
// decoded instruction, checks its condition against the CNZV flags it
// owns, reads Rn, drives the external ALU, writes Rd back and commits flags.
// Optional feature macro: DP_EXEC_CTRL_MOV_BYPASS_EN -- MOV/MVN go from
// IDLE straight to EXEC with a zero Rn operand.
//
// Handshake: an instruction transfers on a rising edge where in_Valid and
// out_Ready are both high; out_Ready is high exactly while the FSM is IDLE,
// and a source seeing out_Ready low must keep in_Valid and its fields stable.
module dp_exec_ctrl
  import dp_exec_ctrl_pkg::*;
#(
  parameter int         WORD_W     = `WordWidth,
  parameter logic [3:0] RESET_CNZV = 4'b0000
) (
  input  logic              in_Clk,
  input  logic              in_Rst,
  input  logic              in_Valid,
  output logic              out_Ready,
  input  logic [3:0]        in_Cond,
  input  logic [3:0]        in_Opcode,
  input  logic              in_SetFlags,
  input  logic [3:0]        in_RnAddr,
  input  logic [3:0]        in_RdAddr,
  input  logic [WORD_W-1:0] in_Op2,
  input  logic              in_ShCarry,
  output logic [3:0]        out_RfRdAddr,
  input  logic [WORD_W-1:0] in_RfRdData,
  output logic [WORD_W-1:0] out_AluRn,
  output logic [WORD_W-1:0] out_AluOp2,
  output logic              out_AluCarry,
  output logic [3:0]        out_AluOpcode,
  input  logic [WORD_W-1:0] in_AluY,
  input  logic [3:0]        in_AluCNZV,
  output logic              out_WrEn,
  output logic [3:0]        out_WrAddr,
  output logic [WORD_W-1:0] out_WrData,
  output logic [3:0]        out_CNZV,
  output logic              out_Done,
  output logic              out_Skipped,
  output logic [2:0]        out_DbgState
);

`ifdef DP_EXEC_CTRL_MOV_BYPASS_EN
  localparam logic MOV_BYPASS = 1'b1;
`else
  localparam logic MOV_BYPASS = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_SKIP = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic [3:0]        opcode_q, opcode_d;
  logic              set_flags_q, set_flags_d;
  logic [3:0]        rd_q, rd_d;
  logic [WORD_W-1:0] op2_q, op2_d;
  logic              sh_carry_q, sh_carry_d;
  logic [WORD_W-1:0] result_q, result_d;
  logic [3:0]        alu_flags_q, alu_flags_d;
  logic [3:0]        cnzv_q, cnzv_d;
  logic [3:0]        rf_rd_addr_q, rf_rd_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [3:0]        wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              skipped_q, skipped_d;
  logic              cond_pass;

  cond_check u_cond_check (
    .in_Cond  (in_Cond),
    .in_CNZV  (cnzv_q),
    .out_Pass (cond_pass)
  );

  // State register and all registered outputs; reset aborts any operation
  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      opcode_q     <= '0;
      set_flags_q  <= 1'b0;
      rd_q         <= '0;
      op2_q        <= '0;
      sh_carry_q   <= 1'b0;
      result_q     <= '0;
      alu_flags_q  <= '0;
      cnzv_q       <= RESET_CNZV;
      rf_rd_addr_q <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      done_q       <= 1'b0;
      skipped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      opcode_q     <= opcode_d;
      set_flags_q  <= set_flags_d;
      rd_q         <= rd_d;
      op2_q        <= op2_d;
      sh_carry_q   <= sh_carry_d;
      result_q     <= result_d;
      alu_flags_q  <= alu_flags_d;
      cnzv_q       <= cnzv_d;
      rf_rd_addr_q <= rf_rd_addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
      skipped_q    <= skipped_d;
    end
  end

  // Next-state and next-output logic; strobes default low every cycle
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    set_flags_d  = set_flags_q;
    rd_d         = rd_q;
    op2_d        = op2_q;
    sh_carry_d   = sh_carry_q;
    result_d     = result_q;
    alu_flags_d  = alu_flags_q;
    cnzv_d       = cnzv_q;
    rf_rd_addr_d = rf_rd_addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_d       = 1'b0;
    skipped_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_Valid) begin
          opcode_d    = in_Opcode;
          set_flags_d = in_SetFlags;
          rd_d        = in_RdAddr;
          op2_d       = in_Op2;
          sh_carry_d  = in_ShCarry;
          if (!cond_pass) begin
            state_d = S_SKIP;
          end else if (MOV_BYPASS && is_move_op(in_Opcode)) begin
            state_d = S_EXEC;
          end else begin
            rf_rd_addr_d = in_RnAddr;
            state_d      = S_READ;
          end
        end
      end
      S_READ: begin
        // Register file samples out_RfRdAddr at the end of this cycle.
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d    = in_AluY;
        alu_flags_d = in_AluCNZV;
        state_d     = S_WB;
      end
      S_WB: begin
        done_d = 1'b1;
        if (!is_test_op(opcode_q)) begin
          wr_en_d   = 1'b1;
          wr_addr_d = rd_q;
          wr_data_d = result_q;
        end
        if (set_flags_q || is_test_op(opcode_q)) begin
          // Logical ops leave V alone; C comes from the shifter via the ALU.
          cnzv_d = is_arith_op(opcode_q) ? alu_flags_q : {alu_flags_q[3:1], cnzv_q[0]};
        end
        state_d = S_IDLE;
      end
      S_SKIP: begin
        done_d    = 1'b1;
        skipped_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  // ALU drive: only meaningful in EXEC, held at zero otherwise
  always_comb begin
    out_AluRn     = '0;
    out_AluOp2    = '0;
    out_AluCarry  = 1'b0;
    out_AluOpcode = '0;
    if (state_q == S_EXEC) begin
      out_AluRn     = (MOV_BYPASS && is_move_op(opcode_q)) ? '0 : in_RfRdData;
      out_AluOp2    = op2_q;
      out_AluOpcode = opcode_q;
      out_AluCarry  = uses_flag_carry(opcode_q) ? cnzv_q[3] : sh_carry_q;
    end
  end

  assign out_Ready    = ready_q;
  assign out_RfRdAddr = rf_rd_addr_q;
  assign out_WrEn     = wr_en_q;
  assign out_WrAddr   = wr_addr_q;
  assign out_WrData   = wr_data_q;
  assign out_CNZV     = cnzv_q;
  assign out_Done     = done_q;
  assign out_Skipped  = skipped_q;
  assign out_DbgState = state_q;

endmodule

// File: tb/tb_dp_exec_ctrl.sv
// Directed bench for dp_exec_ctrl with a behavioural ALU and register file.
module tb_dp_exec_ctrl;

`ifdef DP_EXEC_CTRL_MOV_BYPASS_EN
  localparam int MOV_LAT = 2;
`else
  localparam int MOV_LAT = 3;
`endif

  logic        in_Clk, in_Rst, in_Valid, in_SetFlags, in_ShCarry;
  logic [3:0]  in_Cond, in_Opcode, in_RnAddr, in_RdAddr;
  logic [31:0] in_Op2, in_RfRdData, in_AluY;
  logic [3:0]  in_AluCNZV;
  logic        out_Ready, out_AluCarry, out_WrEn, out_Done, out_Skipped;
  logic [3:0]  out_RfRdAddr, out_AluOpcode, out_WrAddr, out_CNZV;
  logic [31:0] out_AluRn, out_AluOp2, out_WrData;
  logic [2:0]  out_DbgState;

  int pass_cnt = 0;
  int total    = 0;
  int lat;
  int done_cnt;
  logic [31:0] cap_data;
  logic [3:0]  cap_flags;

  logic [31:0] regs [16];

  dp_exec_ctrl dut (
    .in_Clk(in_Clk), .in_Rst(in_Rst), .in_Valid(in_Valid), .out_Ready(out_Ready),
    .in_Cond(in_Cond), .in_Opcode(in_Opcode), .in_SetFlags(in_SetFlags),
    .in_RnAddr(in_RnAddr), .in_RdAddr(in_RdAddr), .in_Op2(in_Op2), .in_ShCarry(in_ShCarry),
    .out_RfRdAddr(out_RfRdAddr), .in_RfRdData(in_RfRdData),
    .out_AluRn(out_AluRn), .out_AluOp2(out_AluOp2), .out_AluCarry(out_AluCarry),
    .out_AluOpcode(out_AluOpcode), .in_AluY(in_AluY), .in_AluCNZV(in_AluCNZV),
    .out_WrEn(out_WrEn), .out_WrAddr(out_WrAddr), .out_WrData(out_WrData),
    .out_CNZV(out_CNZV), .out_Done(out_Done), .out_Skipped(out_Skipped),
    .out_DbgState(out_DbgState)
  );

  // Clock / reset
  initial in_Clk = 1'b0;
  always #5 in_Clk = ~in_Clk;

  // Behavioural ALU: returns {C,N,Z,V, Y}
  function automatic logic [35:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
    logic [32:0] s;
    logic [31:0] y, x1, x2;
    logic c, v, ci, arith;
    arith = 1'b1; c = cin; v = 1'b0; x1 = a; x2 = b; ci = 1'b0; y = '0;
    case (op)
      4'h2, 4'hA: begin x1 = a; x2 = ~b; ci = 1'b1; end
      4'h3:       begin x1 = b; x2 = ~a; ci = 1'b1; end
      4'h4, 4'hB: begin x1 = a; x2 = b;  ci = 1'b0; end
      4'h5:       begin x1 = a; x2 = b;  ci = cin;  end
      4'h6:       begin x1 = a; x2 = ~b; ci = cin;  end
      4'h7:       begin x1 = b; x2 = ~a; ci = cin;  end
      default: arith = 1'b0;
    endcase
    if (arith) begin
      s = {1'b0, x1} + {1'b0, x2} + {32'd0, ci};
      y = s[31:0];
      c = s[32];
      v = (x1[31] == x2[31]) && (y[31] != x1[31]);
    end else begin
      case (op)
        4'h0, 4'h8: y = a & b;
        4'h1, 4'h9: y = a ^ b;
        4'hC:       y = a | b;
        4'hD:       y = b;
        4'hE:       y = a & ~b;
        default:    y = ~b;
      endcase
    end
    return {c, y[31], (y == 32'd0), v, y};
  endfunction

  assign {in_AluCNZV, in_AluY} = alu_model(out_AluOpcode, out_AluRn, out_AluOp2, out_AluCarry);

  // Register file: synchronous read, write on out_WrEn; preloaded on reset
  always @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'd0;
      regs[2] <= 32'h7FFF_FFFF;
      regs[3] <= 32'h0000_0011;
      regs[4] <= 32'd5;
      regs[5] <= 32'd1;
      regs[6] <= 32'h0000_00F0;
      in_RfRdData <= 32'd0;
    end else begin
      in_RfRdData <= regs[out_RfRdAddr];
      if (out_WrEn) regs[out_WrAddr] <= out_WrData;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  // Driver: present one instruction and let it transfer on the next edge
  task automatic issue(input logic [3:0] c, input logic [3:0] op, input logic sb,
                       input logic [3:0] rn, input logic [3:0] rd,
                       input logic [31:0] o2, input logic sc);
    in_Cond = c; in_Opcode = op; in_SetFlags = sb;
    in_RnAddr = rn; in_RdAddr = rd; in_Op2 = o2; in_ShCarry = sc;
    in_Valid = 1'b1;
    check("ready_before_accept", {31'd0, out_Ready}, 32'd1);
    @(posedge in_Clk); #1;
    in_Valid = 1'b0;
    check("ready_busy", {31'd0, out_Ready}, 32'd0);
  endtask

  // Edges after the accept edge until out_Done; -1 on timeout
  task automatic wait_done(output int l);
    l = -1;
    for (int i = 1; i <= 8; i++) begin
      if (l < 0) begin
        @(posedge in_Clk); #1;
        if (out_Done) l = i;
      end
    end
  endtask

  initial begin
    in_Rst = 1'b1; in_Valid = 1'b0; in_Cond = 4'h0; in_Opcode = 4'h0;
    in_SetFlags = 1'b0; in_RnAddr = 4'h0; in_RdAddr = 4'h0; in_Op2 = 32'd0; in_ShCarry = 1'b0;
    repeat (2) @(posedge in_Clk);
    #1;
    check("rst_cnzv", {28'd0, out_CNZV}, 32'h0);
    check("rst_wren", {31'd0, out_WrEn}, 32'd0);
    check("rst_done", {31'd0, out_Done}, 32'd0);
    check("rst_skipped", {31'd0, out_Skipped}, 32'd0);
    check("rst_wraddr", {28'd0, out_WrAddr}, 32'd0);
    check("rst_wrdata", out_WrData, 32'd0);
    check("rst_rdaddr", {28'd0, out_RfRdAddr}, 32'd0);
    check("rst_aluop", {28'd0, out_AluOpcode}, 32'd0);
    in_Rst = 1'b0;
    #1;
    check("rst_ready", {31'd0, out_Ready}, 32'd1);

    // ADDS R1 = R2(0x7FFFFFFF) + 1 : overflow into sign bit
    issue(4'hE, 4'h4, 1'b1, 4'd2, 4'd1, 32'd1, 1'b0);
    wait_done(lat);
    check("adds_lat", lat, 32'd3);
    check("adds_wren", {31'd0, out_WrEn}, 32'd1);
    check("adds_wraddr", {28'd0, out_WrAddr}, 32'd1);
    check("adds_wrdata", out_WrData, 32'h8000_0000);
    check("adds_cnzv", {28'd0, out_CNZV}, 32'h5);
    check("adds_skipped", {31'd0, out_Skipped}, 32'd0);

    // CMP R4(5), #5 : no write, flags C and Z
    issue(4'hE, 4'hA, 1'b0, 4'd4, 4'd0, 32'd5, 1'b0);
    wait_done(lat);
    check("cmp_lat", lat, 32'd3);
    check("cmp_wren", {31'd0, out_WrEn}, 32'd0);
    check("cmp_cnzv", {28'd0, out_CNZV}, 32'hA);

    // MOVNE R3,#7 with Z=1 : skipped
    issue(4'h1, 4'hD, 1'b0, 4'd0, 4'd3, 32'd7, 1'b0);
    wait_done(lat);
    check("movne_lat", lat, 32'd1);
    check("movne_skipped", {31'd0, out_Skipped}, 32'd1);
    check("movne_wren", {31'd0, out_WrEn}, 32'd0);
    check("movne_cnzv", {28'd0, out_CNZV}, 32'hA);

    // ADC R0 = R5(1) + 1 + C(1), S=0 : flags unchanged
    issue(4'hE, 4'h5, 1'b0, 4'd5, 4'd0, 32'd1, 1'b0);
    check("adc_alucarry_read", {31'd0, out_AluCarry}, 32'd0);
    wait_done(lat);
    check("adc_lat", lat, 32'd3);
    check("adc_wrdata", out_WrData, 32'd3);
    check("adc_cnzv", {28'd0, out_CNZV}, 32'hA);
    check("movne_r3_untouched", regs[3], 32'h11);

    // ADDS again to set V, then ANDS with shifter carry : V preserved
    issue(4'hE, 4'h4, 1'b1, 4'd2, 4'd1, 32'd1, 1'b0);
    wait_done(lat);
    check("adds2_cnzv", {28'd0, out_CNZV}, 32'h5);
    issue(4'hE, 4'h0, 1'b1, 4'd6, 4'd7, 32'h0F, 1'b1);
    wait_done(lat);
    check("ands_lat", lat, 32'd3);
    check("ands_wren", {31'd0, out_WrEn}, 32'd1);
    check("ands_wrdata", out_WrData, 32'd0);
    check("ands_cnzv", {28'd0, out_CNZV}, 32'hB);

    // Flags 1011: GE fails, HI fails, LS passes, NV never
    issue(4'hA, 4'hD, 1'b0, 4'd0, 4'd10, 32'd9, 1'b0);
    wait_done(lat);
    check("ge_skipped", {31'd0, out_Skipped}, 32'd1);
    issue(4'h8, 4'hD, 1'b0, 4'd0, 4'd10, 32'd9, 1'b0);
    wait_done(lat);
    check("hi_lat", lat, 32'd1);
    issue(4'h9, 4'hD, 1'b0, 4'd0, 4'd10, 32'd9, 1'b0);
    wait_done(lat);
    check("ls_lat", lat, MOV_LAT);
    check("ls_wrdata", out_WrData, 32'd9);
    check("ls_skipped", {31'd0, out_Skipped}, 32'd0);
    check("ls_cnzv", {28'd0, out_CNZV}, 32'hB);
    issue(4'hF, 4'h4, 1'b1, 4'd2, 4'd1, 32'd1, 1'b0);
    wait_done(lat);
    check("nv_skipped", {31'd0, out_Skipped}, 32'd1);

    // Reset during EXEC of ADDS R8 = R2 + 1 (flag C=1, shifter carry 0)
    issue(4'hE, 4'h4, 1'b1, 4'd2, 4'd8, 32'd1, 1'b0);
    @(posedge in_Clk); #1;
    check("exec_state", {29'd0, out_DbgState}, 32'd2);
    check("exec_alurn", out_AluRn, 32'h7FFF_FFFF);
    check("exec_aluop2", out_AluOp2, 32'd1);
    check("exec_aluopc", {28'd0, out_AluOpcode}, 32'h4);
    check("exec_alucarry", {31'd0, out_AluCarry}, 32'd0);
    in_Rst = 1'b1;
    #1;
    check("abort_wren", {31'd0, out_WrEn}, 32'd0);
    check("abort_cnzv", {28'd0, out_CNZV}, 32'h0);
    check("abort_state", {29'd0, out_DbgState}, 32'd0);
    @(posedge in_Clk); #1;
    in_Rst = 1'b0;
    #1;
    check("abort_ready", {31'd0, out_Ready}, 32'd1);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge in_Clk); #1;
      if (out_Done || out_WrEn) done_cnt++;
    end
    check("abort_no_done", done_cnt, 32'd0);

    // SUBS R9 = R4(5) - 3 with in_Valid held while busy : accepted once
    in_Cond = 4'hE; in_Opcode = 4'h2; in_SetFlags = 1'b1;
    in_RnAddr = 4'd4; in_RdAddr = 4'd9; in_Op2 = 32'd3; in_ShCarry = 1'b0;
    in_Valid = 1'b1;
    @(posedge in_Clk); #1;
    done_cnt = 0; cap_data = '0; cap_flags = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge in_Clk); #1;
      if (out_Done) begin
        done_cnt++;
        cap_data = out_WrData;
        cap_flags = out_CNZV;
      end
      if (i == 2) in_Valid = 1'b0;
    end
    check("hold_single_done", done_cnt, 32'd1);
    check("subs_wrdata", cap_data, 32'd2);
    check("subs_cnzv", {28'd0, cap_flags}, 32'h8);
    check("subs_r9", regs[9], 32'd2);

    // MVNGT R10 = ~0 with S=1 (flags 1000: GT passes)
    issue(4'hC, 4'hF, 1'b1, 4'd0, 4'd10, 32'd0, 1'b0);
    wait_done(lat);
    check("mvn_lat", lat, MOV_LAT);
    check("mvn_wrdata", out_WrData, 32'hFFFF_FFFF);
    check("mvn_cnzv", {28'd0, out_CNZV}, 32'h4);

    @(posedge in_Clk); #1;
    check("final_ready", {31'd0, out_Ready}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  // Global watchdog
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
